in_reg_ctrl: RTL and testbench

IN_REG_CTRL -- requirements
Module: in_reg_ctrl

---
 rtl/in_reg_ctrl_pkg.sv | 32 +++
 rtl/in_reg_ctrl_sampler.sv | 58 +++++
 rtl/in_reg_ctrl.sv | 172 +++++++++++++++++
 tb/tb_in_reg_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/in_reg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// in_reg_ctrl_pkg
// Shared definitions for the input-register cell controller:
//   - state_t        : controller FSM states
//   - CNT_W          : width of the settle down-counter
//   - DEFAULT_NPADS  : default number of controlled cells
//   - DEFAULT_SETTLE : default idle cycles after a mode change
//   - cfg_differs()  : compares a pad's current and requested mode bits
// -----------------------------------------------------------------------------
package in_reg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int CNT_W          = 4;
    localparam int DEFAULT_NPADS  = 8;
    localparam int DEFAULT_SETTLE = 2;

    // True when the requested {isel, fixhold} pair differs from the current one.
    function automatic logic cfg_differs(
        input logic cur_isel,
        input logic cur_fixhold,
        input logic req_isel,
        input logic req_fixhold
    );
        return ({cur_isel, cur_fixhold} != {req_isel, req_fixhold});
    endfunction

endpackage

// File: rtl/in_reg_ctrl_sampler.sv
// -----------------------------------------------------------------------------
// in_reg_ctrl_sampler
// Valid/ready register stage that captures the cell output vector.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   launch_en : high while the controller is idle and may take a new sample
//   iqz       : cell output vector to capture
//   smp_ready : downstream consumer ready
//   smp_valid : registered sample valid
//   smp_data  : registered sample data, stable while valid and not ready
// -----------------------------------------------------------------------------
module in_reg_ctrl_sampler #(
    parameter int NPADS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             launch_en,
    input  logic [NPADS-1:0] iqz,
    input  logic             smp_ready,
    output logic             smp_valid,
    output logic [NPADS-1:0] smp_data
);

    logic             smp_valid_r;
    logic [NPADS-1:0] smp_data_r;
    logic             launch_s;
    logic             drain_s;

    // Launch a new sample when idle and the output slot is free or being emptied.
    always_comb begin
        launch_s = 1'b0;
        drain_s  = 1'b0;
        if (launch_en && (!smp_valid_r || smp_ready)) begin
            launch_s = 1'b1;
        end else begin
            drain_s = smp_valid_r && smp_ready;
        end
    end

    // Sample register stage; data only moves on a launch so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_valid_r <= 1'b0;
            smp_data_r  <= '0;
        end else if (launch_s) begin
            smp_valid_r <= 1'b1;
            smp_data_r  <= iqz;
        end else if (drain_s) begin
            smp_valid_r <= 1'b0;
        end else begin
            smp_valid_r <= smp_valid_r;
        end
    end

    assign smp_valid = smp_valid_r;
    assign smp_data  = smp_data_r;

endmodule

// File: rtl/in_reg_ctrl.sv
// -----------------------------------------------------------------------------
// in_reg_ctrl
// Controller for a bank of input-register cells. A config request changes
// the bypass (ISEL) and hold-fix (FIXHOLD) selects of one pad: the pad's
// register is cleared for one cycle, the new selects load, and the block
// waits SETTLE cycles before sampling the cell outputs again.
//   IQC         : clock, rising edge
//   QRT_N       : asynchronous active-low reset
//   CFG_VALID   : config request valid
//   CFG_READY   : config request accepted (high only in IDLE)
//   CFG_PAD     : target pad index
//   CFG_ISEL    : requested bypass select
//   CFG_FIXHOLD : requested hold-fix select
//   ISEL        : per-pad bypass select (reset all ones)
//   FIXHOLD     : per-pad hold-fix select (reset all zeros)
//   QRT         : per-pad active-high register clear pulse
//   IQZ         : per-pad cell outputs
//   SMP_VALID   : sample valid
//   SMP_READY   : sample consumer ready
//   SMP_DATA    : sampled IQZ vector
//   BUSY        : controller not idle
// -----------------------------------------------------------------------------
module in_reg_ctrl
    import in_reg_ctrl_pkg::*;
#(
    parameter int NPADS  = DEFAULT_NPADS,
    parameter int SETTLE = DEFAULT_SETTLE,
    localparam int PW    = (NPADS > 1) ? $clog2(NPADS) : 1
) (
    input  logic             IQC,
    input  logic             QRT_N,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    input  logic [PW-1:0]    CFG_PAD,
    input  logic             CFG_ISEL,
    input  logic             CFG_FIXHOLD,
    output logic [NPADS-1:0] ISEL,
    output logic [NPADS-1:0] FIXHOLD,
    output logic [NPADS-1:0] QRT,
    input  logic [NPADS-1:0] IQZ,
    output logic             SMP_VALID,
    input  logic             SMP_READY,
    output logic [NPADS-1:0] SMP_DATA,
    output logic             BUSY
);

    localparam logic [PW:0]      NPADS_W  = (PW + 1)'(NPADS);
    localparam logic [CNT_W-1:0] SETTLE_W = CNT_W'(SETTLE);

    state_t             state_r;
    logic [CNT_W-1:0]   settle_cnt_r;
    logic [PW-1:0]      pad_r;
    logic               new_isel_r;
    logic               new_fixhold_r;
    logic [NPADS-1:0]   isel_r;
    logic [NPADS-1:0]   fixhold_r;
    logic [NPADS-1:0]   qrt_r;
    logic               cfg_ready_r;
    logic               busy_r;

    logic               cfg_fire_s;
    logic               cfg_in_range_s;
    logic               cur_isel_s;
    logic               cur_fixhold_s;
    logic               cfg_change_s;
    logic [NPADS-1:0]   pad_onehot_s;

    // Decode an incoming config request: accepted, in range, and actually a change.
    always_comb begin
        cfg_fire_s     = CFG_VALID && cfg_ready_r;
        cfg_in_range_s = ({1'b0, CFG_PAD} < NPADS_W);
        if (cfg_in_range_s) begin
            cur_isel_s    = isel_r[CFG_PAD];
            cur_fixhold_s = fixhold_r[CFG_PAD];
        end else begin
            cur_isel_s    = 1'b1;
            cur_fixhold_s = 1'b0;
        end
        cfg_change_s = cfg_fire_s && cfg_in_range_s &&
                       cfg_differs(cur_isel_s, cur_fixhold_s, CFG_ISEL, CFG_FIXHOLD);
        pad_onehot_s = NPADS'(1'b1) << CFG_PAD;
    end

    // Controller FSM; CFG_READY and BUSY are registered from the next state so
    // CFG_READY stays low during reset and rises on the first edge after release.
    always_ff @(posedge IQC or negedge QRT_N) begin
        if (!QRT_N) begin
            state_r       <= ST_IDLE;
            settle_cnt_r  <= '0;
            pad_r         <= '0;
            new_isel_r    <= 1'b1;
            new_fixhold_r <= 1'b0;
            isel_r        <= '1;
            fixhold_r     <= '0;
            qrt_r         <= '0;
            cfg_ready_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_change_s) begin
                        state_r       <= ST_CLEAR;
                        pad_r         <= CFG_PAD;
                        new_isel_r    <= CFG_ISEL;
                        new_fixhold_r <= CFG_FIXHOLD;
                        qrt_r         <= pad_onehot_s;
                        cfg_ready_r   <= 1'b0;
                        busy_r        <= 1'b1;
                    end else begin
                        qrt_r         <= '0;
                        cfg_ready_r   <= 1'b1;
                        busy_r        <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // New selects load at the edge that ends the clear pulse.
                    qrt_r             <= '0;
                    isel_r[pad_r]     <= new_isel_r;
                    fixhold_r[pad_r]  <= new_fixhold_r;
                    if (SETTLE > 0) begin
                        state_r       <= ST_SETTLE;
                        settle_cnt_r  <= SETTLE_W;
                    end else begin
                        state_r       <= ST_IDLE;
                        cfg_ready_r   <= 1'b1;
                        busy_r        <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    qrt_r <= '0;
                    // Count holds the cycles left including this one.
                    if (settle_cnt_r <= 4'd1) begin
                        state_r       <= ST_IDLE;
                        settle_cnt_r  <= '0;
                        cfg_ready_r   <= 1'b1;
                        busy_r        <= 1'b0;
                    end else begin
                        settle_cnt_r  <= settle_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    settle_cnt_r  <= '0;
                    qrt_r         <= '0;
                    cfg_ready_r   <= 1'b1;
                    busy_r        <= 1'b0;
                end
            endcase
        end
    end

    // cfg_ready_r marks the cycles where the FSM is idle and accepting, which
    // also delays the first sample launch to the second edge after reset.
    in_reg_ctrl_sampler #(
        .NPADS (NPADS)
    ) u_sampler (
        .clk       (IQC),
        .rst_n     (QRT_N),
        .launch_en (cfg_ready_r),
        .iqz       (IQZ),
        .smp_ready (SMP_READY),
        .smp_valid (SMP_VALID),
        .smp_data  (SMP_DATA)
    );

    assign CFG_READY = cfg_ready_r;
    assign BUSY      = busy_r;
    assign ISEL      = isel_r;
    assign FIXHOLD   = fixhold_r;
    assign QRT       = qrt_r;

endmodule

// File: tb/tb_in_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_in_reg_ctrl
// Directed bench for in_reg_ctrl: one instance with defaults (8 pads, settle
// of 2) and one with 6 pads and no settle time for boundary/out-of-range pads.
// -----------------------------------------------------------------------------
module tb_in_reg_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: NPADS=8, SETTLE=2
    logic       a_cfg_valid, a_cfg_ready, a_cfg_isel, a_cfg_fixhold;
    logic [2:0] a_cfg_pad;
    logic [7:0] a_isel, a_fixhold, a_qrt, a_iqz, a_smp_data;
    logic       a_smp_valid, a_smp_ready, a_busy;

    // Instance B: NPADS=6, SETTLE=0
    logic       b_cfg_valid, b_cfg_ready, b_cfg_isel, b_cfg_fixhold;
    logic [2:0] b_cfg_pad;
    logic [5:0] b_isel, b_fixhold, b_qrt, b_iqz, b_smp_data;
    logic       b_smp_valid, b_smp_ready, b_busy;

    in_reg_ctrl #(.NPADS(8), .SETTLE(2)) u_dut_a (
        .IQC(clk), .QRT_N(rst_n),
        .CFG_VALID(a_cfg_valid), .CFG_READY(a_cfg_ready), .CFG_PAD(a_cfg_pad),
        .CFG_ISEL(a_cfg_isel), .CFG_FIXHOLD(a_cfg_fixhold),
        .ISEL(a_isel), .FIXHOLD(a_fixhold), .QRT(a_qrt), .IQZ(a_iqz),
        .SMP_VALID(a_smp_valid), .SMP_READY(a_smp_ready), .SMP_DATA(a_smp_data),
        .BUSY(a_busy)
    );

    in_reg_ctrl #(.NPADS(6), .SETTLE(0)) u_dut_b (
        .IQC(clk), .QRT_N(rst_n),
        .CFG_VALID(b_cfg_valid), .CFG_READY(b_cfg_ready), .CFG_PAD(b_cfg_pad),
        .CFG_ISEL(b_cfg_isel), .CFG_FIXHOLD(b_cfg_fixhold),
        .ISEL(b_isel), .FIXHOLD(b_fixhold), .QRT(b_qrt), .IQZ(b_iqz),
        .SMP_VALID(b_smp_valid), .SMP_READY(b_smp_ready), .SMP_DATA(b_smp_data),
        .BUSY(b_busy)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Count one comparison and report it when observed differs from expected.
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_cfg(input logic [2:0] pad, input logic isel, input logic fixhold);
        a_cfg_valid   = 1'b1;
        a_cfg_pad     = pad;
        a_cfg_isel    = isel;
        a_cfg_fixhold = fixhold;
    endtask

    task automatic b_cfg(input logic [2:0] pad, input logic isel, input logic fixhold);
        b_cfg_valid   = 1'b1;
        b_cfg_pad     = pad;
        b_cfg_isel    = isel;
        b_cfg_fixhold = fixhold;
    endtask

    initial begin
        rst_n       = 1'b0;
        a_cfg_valid = 1'b0; a_cfg_pad = 3'd0; a_cfg_isel = 1'b1; a_cfg_fixhold = 1'b0;
        a_smp_ready = 1'b1; a_iqz = 8'hA5;
        b_cfg_valid = 1'b0; b_cfg_pad = 3'd0; b_cfg_isel = 1'b1; b_cfg_fixhold = 1'b0;
        b_smp_ready = 1'b1; b_iqz = 6'h15;
        #12;

        // Reset state
        chk("rst_cfg_ready", 32'(a_cfg_ready), 32'h0);
        chk("rst_isel",      32'(a_isel),      32'hFF);
        chk("rst_fixhold",   32'(a_fixhold),   32'h00);
        chk("rst_qrt",       32'(a_qrt),       32'h00);
        chk("rst_smp_valid", 32'(a_smp_valid), 32'h0);
        chk("rst_smp_data",  32'(a_smp_data),  32'h00);
        chk("rst_busy",      32'(a_busy),      32'h0);
        rst_n = 1'b1;

        tick();
        chk("rel1_cfg_ready", 32'(a_cfg_ready), 32'h1);
        chk("rel1_smp_valid", 32'(a_smp_valid), 32'h0);
        tick();
        chk("rel2_smp_valid", 32'(a_smp_valid), 32'h1);
        chk("rel2_smp_data",  32'(a_smp_data),  32'hA5);

        // Pad 3 -> ISEL=0 FIXHOLD=1, simultaneous sample handshake with IQZ=3C
        a_cfg(3'd3, 1'b0, 1'b1);
        a_iqz = 8'h3C;
        tick();                                   // t+1 : CLEAR
        a_cfg_valid = 1'b0;
        a_iqz = 8'h11;
        chk("p3_t1_qrt",       32'(a_qrt),       32'h08);
        chk("p3_t1_busy",      32'(a_busy),      32'h1);
        chk("p3_t1_ready",     32'(a_cfg_ready), 32'h0);
        chk("p3_t1_isel",      32'(a_isel),      32'hFF);
        chk("p3_t1_smp_data",  32'(a_smp_data),  32'h3C);
        tick();                                   // t+2 : SETTLE
        chk("p3_t2_qrt",       32'(a_qrt),       32'h00);
        chk("p3_t2_isel",      32'(a_isel),      32'hF7);
        chk("p3_t2_fixhold",   32'(a_fixhold),   32'h08);
        chk("p3_t2_smp_valid", 32'(a_smp_valid), 32'h0);
        tick();                                   // t+3 : SETTLE
        chk("p3_t3_ready",     32'(a_cfg_ready), 32'h0);
        chk("p3_t3_smp_valid", 32'(a_smp_valid), 32'h0);
        tick();                                   // t+4 : IDLE
        chk("p3_t4_ready",     32'(a_cfg_ready), 32'h1);
        chk("p3_t4_busy",      32'(a_busy),      32'h0);
        chk("p3_t4_smp_valid", 32'(a_smp_valid), 32'h0);
        tick();                                   // t+5 : first launch after change
        chk("p3_t5_smp_valid", 32'(a_smp_valid), 32'h1);
        chk("p3_t5_smp_data",  32'(a_smp_data),  32'h11);

        // Same values again: no-op
        a_cfg(3'd3, 1'b0, 1'b1);
        tick();
        a_cfg_valid = 1'b0;
        chk("same_qrt",   32'(a_qrt),       32'h00);
        chk("same_busy",  32'(a_busy),      32'h0);
        chk("same_ready", 32'(a_cfg_ready), 32'h1);

        // Backpressure: data holds while IQZ toggles
        a_smp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_iqz = 8'(i * 37 + 1);
            tick();
            chk("bp_smp_data",  32'(a_smp_data),  32'h11);
            chk("bp_smp_valid", 32'(a_smp_valid), 32'h1);
        end
        a_smp_ready = 1'b1;
        a_iqz = 8'h5A;
        tick();
        chk("bp_rel_smp_data", 32'(a_smp_data), 32'h5A);

        // Backpressure across a mode change: data held through CLEAR/SETTLE
        a_smp_ready = 1'b0;
        a_cfg(3'd0, 1'b0, 1'b0);
        a_iqz = 8'hC3;
        tick();                                   // CLEAR
        a_cfg_valid = 1'b0;
        chk("hold_clr_qrt",  32'(a_qrt),      32'h01);
        chk("hold_clr_data", 32'(a_smp_data), 32'h5A);
        tick();                                   // SETTLE
        chk("hold_set_isel", 32'(a_isel),     32'hF6);
        tick();
        tick();                                   // IDLE
        chk("hold_idle_data",  32'(a_smp_data),  32'h5A);
        chk("hold_idle_valid", 32'(a_smp_valid), 32'h1);
        a_smp_ready = 1'b1;
        tick();
        chk("hold_new_data", 32'(a_smp_data), 32'hC3);

        // Reset during SETTLE aborts and restores reset configuration
        a_cfg(3'd5, 1'b0, 1'b1);
        tick();                                   // CLEAR
        a_cfg_valid = 1'b0;
        tick();                                   // SETTLE
        chk("abort_pre_isel",    32'(a_isel),    32'hD6);
        chk("abort_pre_fixhold", 32'(a_fixhold), 32'h28);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_isel",      32'(a_isel),      32'hFF);
        chk("abort_fixhold",   32'(a_fixhold),   32'h00);
        chk("abort_qrt",       32'(a_qrt),       32'h00);
        chk("abort_busy",      32'(a_busy),      32'h0);
        chk("abort_ready",     32'(a_cfg_ready), 32'h0);
        chk("abort_smp_valid", 32'(a_smp_valid), 32'h0);
        chk("abort_smp_data",  32'(a_smp_data),  32'h00);
        rst_n = 1'b1;
        tick();
        chk("abort_rel_ready", 32'(a_cfg_ready), 32'h1);
        chk("abort_rel_isel",  32'(a_isel),      32'hFF);

        // Instance B: SETTLE=0, pad 0
        b_cfg(3'd0, 1'b0, 1'b1);
        tick();                                   // CLEAR
        b_cfg_valid = 1'b0;
        chk("b0_t1_qrt",   32'(b_qrt),       32'h01);
        chk("b0_t1_busy",  32'(b_busy),      32'h1);
        chk("b0_t1_ready", 32'(b_cfg_ready), 32'h0);
        chk("b0_t1_isel",  32'(b_isel),      32'h3F);
        tick();                                   // IDLE at t+2
        chk("b0_t2_ready",   32'(b_cfg_ready), 32'h1);
        chk("b0_t2_busy",    32'(b_busy),      32'h0);
        chk("b0_t2_isel",    32'(b_isel),      32'h3E);
        chk("b0_t2_fixhold", 32'(b_fixhold),   32'h01);
        chk("b0_t2_qrt",     32'(b_qrt),       32'h00);

        // Out-of-range pad 7 with NPADS=6: accepted no-op
        b_cfg(3'd7, 1'b0, 1'b1);
        tick();
        b_cfg_valid = 1'b0;
        chk("oor_qrt",   32'(b_qrt),       32'h00);
        chk("oor_busy",  32'(b_busy),      32'h0);
        chk("oor_ready", 32'(b_cfg_ready), 32'h1);
        tick();
        chk("oor_isel",    32'(b_isel),    32'h3E);
        chk("oor_fixhold", 32'(b_fixhold), 32'h01);

        // Highest in-range pad
        b_cfg(3'd5, 1'b0, 1'b0);
        tick();
        b_cfg_valid = 1'b0;
        chk("b5_qrt", 32'(b_qrt), 32'h20);
        tick();
        chk("b5_isel",  32'(b_isel),      32'h1E);
        chk("b5_ready", 32'(b_cfg_ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
